// File: rtl/cdce_serial_pkg.sv
// Shared CDCE serial definitions: word/count/address widths and FSM states.
// Intended for reuse by both the serial transmitter and receiver.
package cdce_serial_pkg;

  localparam int CDCE_WORD_WIDTH = 20;
  localparam int CDCE_CNT_WIDTH  = 5;
  localparam int CDCE_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK
  } cdce_state_e;

endpackage

// File: rtl/cdce_shadow_regs.sv
// Per-address shadow copy of received CDCE words, indexed by word[3:0].
// Combinational read; a same-cycle write is not visible until the next cycle.
module cdce_shadow_regs
  import cdce_serial_pkg::*;
#(
  parameter int WORD_WIDTH = CDCE_WORD_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       we,
  input  logic [WORD_WIDTH-1:0]      wdata,
  input  logic [CDCE_ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 2 ** CDCE_ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wdata[CDCE_ADDR_WIDTH-1:0]] <= wdata;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cdce_serial_in.sv
// CDCE serial receiver: deserializes cs_n/mosi frames, flags bad lengths.
// Define CDCE_SERIAL_IN_SHADOW_EN to add the per-address shadow array.
module cdce_serial_in
  import cdce_serial_pkg::*;
#(
  parameter int WORD_WIDTH = CDCE_WORD_WIDTH,
  parameter int CNT_WIDTH  = CDCE_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic [WORD_WIDTH-1:0] parallel_output,
  output logic                  word_valid,
  output logic                  frame_error,
  output logic                  busy
`ifdef CDCE_SERIAL_IN_SHADOW_EN
  ,
  input  logic [CDCE_ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0]      rd_data
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_GOOD = CNT_WIDTH'(WORD_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  cdce_state_e           state, state_n;
  logic                  cs_q, mosi_q;
  logic                  armed;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  logic [WORD_WIDTH-1:0] shift, shift_n;
  logic                  good, bad, start;

  // armed stays low after reset until a real high cs_n has been registered,
  // so a frame already under way at reset release is never joined midway.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q   <= 1'b1;
      mosi_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      cs_q   <= cs_n;
      mosi_q <= mosi;
      armed  <= armed | cs_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  assign start = !cs_q && enable && armed;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    good    = 1'b0;
    bad     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SHIFT;
          cnt_n   = CNT_ONE;
          shift_n = {shift[WORD_WIDTH-2:0], mosi_q};
        end
      end
      ST_SHIFT: begin
        if (!cs_q) begin
          shift_n = {shift[WORD_WIDTH-2:0], mosi_q};
          cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        end else begin
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        good = (cnt == CNT_GOOD);
        bad  = !good;
        if (start) begin
          state_n = ST_SHIFT;
          cnt_n   = CNT_ONE;
          shift_n = {shift[WORD_WIDTH-2:0], mosi_q};
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt             <= '0;
      shift           <= '0;
      parallel_output <= '0;
      word_valid      <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      shift       <= shift_n;
      word_valid  <= good;
      frame_error <= bad;
      if (good) begin
        parallel_output <= shift;
      end
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef CDCE_SERIAL_IN_SHADOW_EN
  cdce_shadow_regs #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shadow (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (word_valid),
    .wdata   (parallel_output),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
`endif

endmodule

// File: doc/cdce_serial_in.md
# cdce_serial_in

Receive-side counterpart of the CDCE serial command path. It monitors the `cs_n`/`mosi` pair driven toward the CDCE clock synthesizer and deserializes each chip-select frame into a 20-bit parallel word. It flags frames whose bit count is not exactly 20. It is used for in-FPGA loopback checking of the programming sequencer and as a capture point for command logging. Optionally, it keeps a per-address shadow copy of the last word written.

## Interface
- `WORD_WIDTH`, default 20: bits per frame; must match the transmitter word width.
- `CNT_WIDTH`, default 5: width of the bit counter; the counter saturates at 2^CNT_WIDTH-1.
- `clk` input, 1 bit: single system clock; `cs_n`/`mosi` are synchronous to it.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: high allows a new frame to start; a frame already in progress always completes.
- `cs_n` input, 1 bit: active-low frame select, as driven by the transmitter.
- `mosi` input, 1 bit: serial data, MSB first, one bit per `clk` while `cs_n` is low.
- `parallel_output` output, 20 bits: last good word; holds its value until the next good frame.
- `word_valid` output, 1 bit: one-cycle pulse when `parallel_output` updates.
- `frame_error` output, 1 bit: one-cycle pulse for a frame with bit count ≠ 20.
- `busy` output, 1 bit: high in SHIFT and CHECK.
- With `CDCE_SERIAL_IN_SHADOW_EN` only:
  - `rd_addr` input, 4 bits
  - `rd_data` output, 20 bits

## Operation
- Input stage: `cs_n` and `mosi` are registered once into `cs_q` and `mosi_q`. All FSM decisions use the registered copies.
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE → SHIFT when `cs_q`=0 and `enable`=1. The bit count loads to 1 and `mosi_q` is shifted in.
  - SHIFT, `cs_q`=0: `shift <= {shift[18:0], mosi_q}`; count increments, saturating at 31 (no wrap).
  - SHIFT, `cs_q`=1: go to CHECK.
  - CHECK, count == 20: `parallel_output <= shift`, `word_valid` pulses.
  - CHECK, count ≠ 20 (short frame, or overrun > 20): `frame_error` pulses and `parallel_output` is unchanged.
  - CHECK → SHIFT if `cs_q`=0 and `enable`=1 (back-to-back frame, count=1, bit captured); otherwise → IDLE.
- The first bit received lands in `parallel_output[19]`. Overrun frames keep shifting, so the shift register holds the last 20 bits, but those bits are discarded.
- `enable` falling during SHIFT does not abort the frame.
- Reset values: `parallel_output`=0, `word_valid`=0, `frame_error`=0, `busy`=0, FSM=IDLE, count=0, shift=0, `cs_q`=1, `mosi_q`=0.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, a frame already under way is ignored until `cs_q` has been seen high, so the receiver never enters SHIFT partway into a frame.

## Timing
- Bit capture: `mosi` is sampled on the same rising edge that samples `cs_n` low. Bit N is committed one edge later through the input register.
- Latency: let E be the first edge at which `cs_n` is sampled high after a frame. `word_valid` or `frame_error` is high during the cycle after edge E+2, for exactly one cycle.
- Minimum `cs_n` high gap accepted between frames: 1 cycle. The transmitter guarantees at least 3.
- `word_valid` and `frame_error` are never high in the same cycle.

## Configuration
- Macro `CDCE_SERIAL_IN_SHADOW_EN`.
- Defined:
  - On each `word_valid`, the word is also written to a 16-entry × 20-bit shadow array indexed by `word[3:0]` (the CDCE register address field).
  - `rd_data` = `shadow[rd_addr]`, combinational read.
  - All entries reset to 0.
  - A `rd_addr` read in the same cycle as a write to that address returns the old value.
- Undefined: no array, and no `rd_addr`/`rd_data` ports.

## Structure
- Package `cdce_serial_pkg`:
  - `CDCE_WORD_WIDTH` = 20
  - `CDCE_CNT_WIDTH` = 5
  - `CDCE_ADDR_WIDTH` = 4
  - FSM state enum
- The same package is to be shared with the transmitter in future edits.
- Sub-module `cdce_shadow_regs` holds the shadow array and its read port. It is instantiated only under `CDCE_SERIAL_IN_SHADOW_EN`.

## Test plan
- Good frame: `cs_n` low for 20 cycles carrying 20'hA5C3F → after `cs_n` rises, a single `word_valid` pulse with `parallel_output`=20'hA5C3F; `frame_error` stays 0.
- Short frame: `cs_n` low for 19 cycles → `frame_error` pulses once; `parallel_output` keeps the previous word; no `word_valid`.
- Overrun: 25 bits sent → `frame_error` pulses once. A 40-cycle frame → count saturates at 31 without wrapping, and still exactly one `frame_error`.
- Back-to-back: 20'h12345 and 20'h6789A separated by a 1-cycle `cs_n` high gap → two `word_valid` pulses with the correct words. Then drive `enable`=0 at the start of a frame → frame ignored; `enable`=0 asserted mid-frame → frame still captured.
- Reset mid-frame: assert `reset_n`=0 at bit 10 → all outputs 0 at once. Release while `cs_n` is still low → no event is reported for that frame, and the next clean frame is captured correctly.
- Shadow (macro on): write 20'h0F0F1 then 20'h11111 (address 1) → `rd_addr`=1 returns 20'h11111; address 2 returns 0. A same-cycle read of address 1 returns the old value.
